demux10_buf: RTL and testbench

//  1-to-10 routing demultiplexer; the distribution counterpart of the 10-input selector.
//  - Accepts a 32-bit word plus a 4-bit destination index on a valid/ready input.
//  - Delivers the word to one of 10 output channels.
//  - Each channel has a one-entry holding register, so the channels drain independently.
//  - Sits between a producer and ten consumers in the datapath, e.g. result distribution.

---
 rtl/demux10_pkg.sv | 20 ++
 rtl/demux_slot.sv | 58 +++++
 rtl/demux10_buf.sv | 105 ++++++++++
 tb/tb_demux10_buf.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/demux10_pkg.sv
// demux10_pkg: shared constants and types for the 1-to-10 routing demultiplexer.
//   NUM_CH       number of output channels (fixed at 10)
//   SEL_W        width of the destination index
//   DATA_W       width of every data word
//   word_t       one data word
//   slot_state_e occupancy of a channel's one-entry holding register
package demux10_pkg;

  localparam int NUM_CH = 10;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry holding register for a single output channel.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   i_push  in   load i_data this cycle (the caller only pushes when the slot can take it)
//   i_pop   in   consumer takes the word this cycle (ignored while empty)
//   i_data  in   word to load on push
//   o_full  out  slot holds a word
//   o_data  out  held word; keeps its last value while empty
module demux_slot
  import demux10_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  logic  i_pop,
  input  word_t i_data,
  output logic  o_full,
  output word_t o_data
);

  slot_state_e r_state;
  slot_state_e w_next_state;
  word_t       r_data;

  // Occupancy register; reset empties the slot and discards its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A push always leaves the slot full, so a simultaneous pop and push
  // replaces the word without a bubble. A pop on an empty slot does nothing.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_push) w_next_state = SLOT_FULL;
      SLOT_FULL:  if (i_pop && !i_push) w_next_state = SLOT_EMPTY;
      default:    w_next_state = SLOT_EMPTY;
    endcase
  end

  // Data register only loads on push, so the word is stable while the slot is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_push) begin
      r_data <= i_data;
    end
  end

  assign o_full = (r_state == SLOT_FULL);
  assign o_data = r_data;

endmodule

// File: rtl/demux10_buf.sv
// demux10_buf: 1-to-10 routing demultiplexer with a one-entry holding register
// per channel so that consumers drain independently.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word present
//   in_ready   out  input can be accepted this cycle (independent of in_valid)
//   in_sel     in   destination channel 0..9; 10..15 are accepted and dropped
//   in_data    in   input word
//   out_valid  out  per-channel holding register full
//   out_ready  in   per-channel consumer takes the word this cycle
//   out_data   out  per-channel holding register contents
//   sel_err    out  sticky flag: an out-of-range beat was accepted
//   err_cnt    out  saturating count of dropped beats (only with DEMUX10_ERR_CNT_EN)
// Optional feature macro: DEMUX10_ERR_CNT_EN adds the err_cnt port and counter.
module demux10_buf
  import demux10_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  word_t                  in_data,
  output logic [NUM_CH-1:0]      out_valid,
  input  logic [NUM_CH-1:0]      out_ready,
  output word_t [NUM_CH-1:0]     out_data,
  output logic                   sel_err
`ifdef DEMUX10_ERR_CNT_EN
  ,
  output logic [7:0]             err_cnt
`endif
);

  logic              w_sel_oor;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_drop;
  logic [NUM_CH-1:0] w_push;
  logic              r_sel_err;

  assign w_sel_oor = (in_sel >= SEL_W'(NUM_CH));

  // Out-of-range beats are always taken so a bad index can never stall the
  // producer; an in-range beat needs its slot empty or draining this cycle.
  always_comb begin
    w_in_ready = 1'b1;
    if (!w_sel_oor) begin
      w_in_ready = ~out_valid[in_sel] | out_ready[in_sel];
    end
  end

  assign in_ready = w_in_ready;
  assign w_accept = in_valid & w_in_ready;
  assign w_drop   = w_accept & w_sel_oor;

  // One-hot push decode; at most one channel is loaded per cycle.
  always_comb begin
    w_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_accept && !w_sel_oor && (in_sel == SEL_W'(i))) begin
        w_push[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push[g]),
      .i_pop  (out_ready[g]),
      .i_data (in_data),
      .o_full (out_valid[g]),
      .o_data (out_data[g])
    );
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_drop) begin
      r_sel_err <= 1'b1;
    end
  end

  assign sel_err = r_sel_err;

`ifdef DEMUX10_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // Saturating count of dropped beats; holds at 8'hFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (w_drop && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_demux10_buf.sv
// tb_demux10_buf: self-checking bench for demux10_buf. A channel-occupancy
// model tracks which channels hold which word; a compare process checks the
// DUT against it every cycle, and directed steps pin literal expectations.
module tb_demux10_buf;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_sel = '0;
  logic [31:0]      in_data = '0;
  logic [9:0]       out_valid;
  logic [9:0]       out_ready = '0;
  logic [9:0][31:0] out_data;
  logic             sel_err;
`ifdef DEMUX10_ERR_CNT_EN
  logic [7:0]       err_cnt;
`endif

  int nVectors = 0;
  int nMiscompares = 0;
  bit checkEn = 1'b0;

  // Behavioural model of the channel contents
  bit [9:0]    mFull;
  logic [31:0] mData [10];
  bit          mErr;
  int          mErrCnt;
  int          pushTotal;
  int          deliverTotal;

  demux10_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel_err   (sel_err)
`ifdef DEMUX10_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input int sel, input logic [31:0] d, input logic [9:0] rdy);
    in_valid  = v;
    in_sel    = 4'(sel);
    in_data   = d;
    out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetModel();
    mFull = '0;
    mErr = 1'b0;
    mErrCnt = 0;
    pushTotal = 0;
    deliverTotal = 0;
    for (int i = 0; i < 10; i++) mData[i] = '0;
  endtask

  // A word can be accepted unless its channel is occupied and not draining.
  function automatic bit modelReady();
    if (in_sel >= 4'd10) return 1'b1;
    return !mFull[in_sel] || out_ready[in_sel];
  endfunction

  // Reset throws away everything the channels were holding.
  always @(negedge rst_n) resetModel();

  // Model update at each edge: drain ready channels, then place the accepted word.
  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = in_valid && modelReady();
      for (int c = 0; c < 10; c++) begin
        if (mFull[c] && out_ready[c]) mFull[c] = 1'b0;
      end
      if (acc) begin
        if (in_sel < 4'd10) begin
          mFull[in_sel] = 1'b1;
          mData[in_sel] = in_data;
          pushTotal++;
        end else begin
          mErr = 1'b1;
          if (mErrCnt < 255) mErrCnt++;
        end
      end
    end
  end

  // Compare the DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (rst_n && checkEn) begin
      checkOutput("out_valid", 32'(out_valid), 32'(mFull));
      checkOutput("sel_err", 32'(sel_err), 32'(mErr));
      checkOutput("in_ready", 32'(in_ready), 32'(modelReady()));
`ifdef DEMUX10_ERR_CNT_EN
      checkOutput("err_cnt", 32'(err_cnt), 32'(mErrCnt));
`endif
      for (int c = 0; c < 10; c++) begin
        if (mFull[c]) checkOutput($sformatf("out_data[%0d]", c), out_data[c], mData[c]);
        if (out_valid[c] && out_ready[c]) deliverTotal++;
      end
    end
  end

  initial begin
    resetModel();
    applyStimulus(0, 0, 32'h0, 10'h0);
    #12;
    rst_n = 1'b1;
    step();

    // Reset state
    checkOutput("reset out_valid", 32'(out_valid), 32'h0);
    checkOutput("reset sel_err", 32'(sel_err), 32'h0);
    checkOutput("reset out_data[3]", out_data[3], 32'h0);
    checkEn = 1'b1;

    // Single push to channel 3 with consumers stalled
    applyStimulus(1, 3, 32'hDEADBEEF, 10'h0);
    #1 checkOutput("t1 in_ready before", 32'(in_ready), 32'h1);
    step();
    checkOutput("t1 out_valid", 32'(out_valid), 32'h008);
    checkOutput("t1 out_data[3]", out_data[3], 32'hDEADBEEF);
    checkOutput("t1 in_ready full", 32'(in_ready), 32'h0);
    applyStimulus(0, 3, 32'h0, 10'h008);
    step();
    checkOutput("t1 drained", 32'(out_valid), 32'h0);

    // Fill every channel, then drain them all at once
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, i, 32'(i), 10'h0);
      step();
    end
    applyStimulus(0, 0, 32'h0, 10'h0);
    #1 checkOutput("t2 all full", 32'(out_valid), 32'h3FF);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("t2 out_data[%0d]", i), out_data[i], 32'(i));
    applyStimulus(0, 0, 32'h0, 10'h3FF);
    step();
    checkOutput("t2 all empty", 32'(out_valid), 32'h0);

    // Pop and push the same channel in one cycle
    applyStimulus(1, 5, 32'hA, 10'h0);
    step();
    applyStimulus(1, 5, 32'hB, 10'h020);
    #1 checkOutput("t3 in_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("t3 out_valid", 32'(out_valid), 32'h020);
    checkOutput("t3 out_data[5]", out_data[5], 32'hB);

    // Out-of-range index is accepted and dropped
    applyStimulus(1, 12, 32'h55, 10'h0);
    #1 checkOutput("t4 in_ready", 32'(in_ready), 32'h1);
    step();
    checkOutput("t4 out_valid", 32'(out_valid), 32'h020);
    checkOutput("t4 sel_err", 32'(sel_err), 32'h1);
`ifdef DEMUX10_ERR_CNT_EN
    checkOutput("t4 err_cnt", 32'(err_cnt), 32'h1);
    for (int i = 0; i < 299; i++) step();
    checkOutput("t4 err_cnt sat", 32'(err_cnt), 32'hFF);
`endif

    // Asynchronous reset in the middle of a cycle
    applyStimulus(1, 7, 32'h77, 10'h0);
    step();
    applyStimulus(0, 0, 32'h0, 10'h0);
    #1 checkOutput("t5 before reset", 32'(out_valid), 32'h0A0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("t5 out_valid", 32'(out_valid), 32'h0);
    checkOutput("t5 sel_err", 32'(sel_err), 32'h0);
    checkOutput("t5 out_data[7]", out_data[7], 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();

    // Random traffic with random consumer back-pressure
    for (int n = 0; n < 6000; n++) begin
      applyStimulus(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 11)),
                    $urandom, 10'($urandom));
      step();
    end
    applyStimulus(0, 0, 32'h0, 10'h3FF);
    step();
    step();
    checkOutput("drain empty", 32'(out_valid), 32'h0);
    checkOutput("words delivered", 32'(deliverTotal), 32'(pushTotal));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
